// File: rtl/player_gun_pkg.sv
// Shared types and default constants for the player gun block.
package gun_pkg;

  typedef enum logic [1:0] {
    S_OVER,
    S_READY,
    S_COOLDOWN,
    S_RELOAD
  } gun_state_t;

  localparam int COOLDOWN_TICKS_DEF = 2_499_999;
  localparam int RELOAD_TICKS_DEF   = 49_999_999;
  localparam int MAX_AMMO_DEF       = 6;
  localparam int CROSS_R_DEF        = 4;
  localparam int SCORE_W            = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/player_gun_tick_timer.sv
// Loadable down-counter shared by the cooldown and reload phases.
// It parks at zero and reports zero until the next load.
module tick_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // NOTE: count_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (count_q != '0) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/player_gun.sv
// Player-side shot initiator: trigger edge detect, cooldown/ammo/reload FSM,
// kill scoring and crosshair render bit.
module player_gun
  import gun_pkg::*;
#(
  parameter int COOLDOWN_TICKS = COOLDOWN_TICKS_DEF,
  parameter int RELOAD_TICKS   = RELOAD_TICKS_DEF,
  parameter int MAX_AMMO       = MAX_AMMO_DEF,
  parameter int CROSS_R        = CROSS_R_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          gameover,
  input  logic                          trigger,
  input  logic [9:0]                    aim_x,
  input  logic [8:0]                    aim_y,
  input  logic [9:0]                    x,
  input  logic [8:0]                    y,
  input  logic                          killed,
  output logic                          shot,
  output logic [9:0]                    shoot_x,
  output logic [8:0]                    shoot_y,
  output logic [$clog2(MAX_AMMO+1)-1:0] ammo,
  output logic                          reloading,
  output logic [SCORE_W-1:0]            score,
  output logic                          render
);

  localparam int AMMO_W  = $clog2(MAX_AMMO + 1);
  localparam int TIMER_W = $clog2(max_int(COOLDOWN_TICKS, RELOAD_TICKS) + 1);

  localparam logic [AMMO_W-1:0]  AMMO_FULL   = AMMO_W'(MAX_AMMO);
  localparam logic [TIMER_W-1:0] COOL_LOAD   = TIMER_W'(COOLDOWN_TICKS);
  localparam logic [TIMER_W-1:0] RELOAD_LOAD = TIMER_W'(RELOAD_TICKS);
  localparam logic [10:0]        CR_X        = 11'(CROSS_R);
  localparam logic [9:0]         CR_Y        = 10'(CROSS_R);

  gun_state_t         state_q, state_d;
  logic               shot_q, shot_d;
  logic [9:0]         shoot_x_q, shoot_x_d;
  logic [8:0]         shoot_y_q, shoot_y_d;
  logic [AMMO_W-1:0]  ammo_q, ammo_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               trig_prev_q;
  logic               fire;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_value;
  logic               timer_zero;

  tick_timer #(.W(TIMER_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .value (timer_value),
    .zero  (timer_zero)
  );

  assign fire = trigger & ~trig_prev_q;

  always_comb begin
    state_d     = state_q;
    shot_d      = 1'b0;
    shoot_x_d   = shoot_x_q;
    shoot_y_d   = shoot_y_q;
    ammo_d      = ammo_q;
    score_d     = score_q;
    timer_load  = 1'b0;
    timer_value = '0;

    if (state_q != S_OVER && killed && score_q != {SCORE_W{1'b1}}) begin
      score_d = score_q + SCORE_W'(1);
    end

    // gameover pre-empts every other move, including a same-cycle fire
    if (state_q != S_OVER && gameover) begin
      state_d = S_OVER;
    end else begin
      case (state_q)
        S_OVER: begin
          if (start && !gameover) begin
            state_d = S_READY;
            ammo_d  = AMMO_FULL;
            score_d = '0;
          end
        end
        S_READY: begin
          if (ammo_q == '0) begin
            state_d     = S_RELOAD;
            timer_load  = 1'b1;
            timer_value = RELOAD_LOAD;
          end else if (fire) begin
            state_d     = S_COOLDOWN;
            shot_d      = 1'b1;
            shoot_x_d   = aim_x;
            shoot_y_d   = aim_y;
            ammo_d      = ammo_q - AMMO_W'(1);
            timer_load  = 1'b1;
            timer_value = COOL_LOAD;
          end
        end
        S_COOLDOWN: begin
          if (timer_zero) begin
            if (ammo_q == '0) begin
              state_d     = S_RELOAD;
              timer_load  = 1'b1;
              timer_value = RELOAD_LOAD;
            end else begin
              state_d = S_READY;
            end
          end
        end
        S_RELOAD: begin
          if (timer_zero) begin
            state_d = S_READY;
            ammo_d  = AMMO_FULL;
          end
        end
        default: state_d = S_OVER;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_OVER;
      shot_q      <= 1'b0;
      shoot_x_q   <= '0;
      shoot_y_q   <= '0;
      ammo_q      <= '0;
      score_q     <= '0;
      trig_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shot_q      <= shot_d;
      shoot_x_q   <= shoot_x_d;
      shoot_y_q   <= shoot_y_d;
      ammo_q      <= ammo_d;
      score_q     <= score_d;
      trig_prev_q <= trigger;
    end
  end

  // Differences are taken one bit wider than the operands so screen edges never wrap.
  logic [10:0] dx, dx_abs;
  logic [9:0]  dy, dy_abs;

  always_comb begin
    dx     = {1'b0, x} - {1'b0, aim_x};
    dy     = {1'b0, y} - {1'b0, aim_y};
    dx_abs = dx[10] ? (~dx + 11'd1) : dx;
    dy_abs = dy[9]  ? (~dy + 10'd1) : dy;
    render = (state_q != S_OVER) &&
             (((y == aim_y) && (dx_abs <= CR_X)) || ((x == aim_x) && (dy_abs <= CR_Y)));
  end

  assign shot      = shot_q;
  assign shoot_x   = shoot_x_q;
  assign shoot_y   = shoot_y_q;
  assign ammo      = ammo_q;
  assign score     = score_q;
  assign reloading = (state_q == S_RELOAD);

endmodule
